// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data stage) for a single shared memory port.
// Round-robin on ties, fixed LATENCY-cycle accesses, one-cycle Grant/Done pulse in RESP.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic        IF_Grant,
  output logic [31:0] IF_RData,
  input  logic        MEM_Req,
  input  logic        MEM_Wre,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  output logic        MEM_Done,
  output logic [31:0] MEM_RData,
  output logic        Mem_En,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  input  logic [31:0] Mem_RData,
  output logic        PipeStall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(LATENCY - 1);

  // owner/last_served encoding: 0 = IF, 1 = MEM
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wre_q, wre_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        win_mem;
  logic        in_access;

  // MEM wins when it is the only requester or when IF was served last.
  assign win_mem = MEM_Req & (~IF_Req | ~last_q);

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wre_q       <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wre_q       <= wre_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state logic: arbitration and latching in IDLE, counting in ACCESS, read capture on exit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wre_d       = wre_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (IF_Req | MEM_Req) begin
          state_d = ACCESS;
          cnt_d   = 3'd0;
          owner_d = win_mem;
          last_d  = win_mem;
          addr_d  = win_mem ? MEM_Addr : IF_Addr;
          wdata_d = win_mem ? MEM_WData : 32'h0;
          wre_d   = win_mem & MEM_Wre;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          if (!owner_q) begin
            if_rdata_d = Mem_RData;
          end else if (!wre_q) begin
            mem_rdata_d = Mem_RData;
          end else begin
            mem_rdata_d = mem_rdata_q;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port is decoded from registered state so it drops as soon as Reset asserts.
  assign in_access = (state_q == ACCESS);
  assign Mem_En    = in_access;
  assign Mem_We    = in_access & owner_q & wre_q;
  assign Mem_Addr  = in_access ? addr_q : 32'h0;
  assign Mem_WData = in_access ? wdata_q : 32'h0;

  assign IF_Grant  = (state_q == RESP) & ~owner_q;
  assign MEM_Done  = (state_q == RESP) & owner_q;
  assign IF_RData  = if_rdata_q;
  assign MEM_RData = mem_rdata_q;
  assign PipeStall = (IF_Req & ~IF_Grant) | (MEM_Req & ~MEM_Done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector tables (LATENCY=2 and LATENCY=1 instances),
// constrained-random traffic against a slot-timing reference model, and a reset-abort sequence.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        if_req, mem_req, mem_wre;
  logic [31:0] if_addr, mem_addr, mem_wdata;

  logic        d0_ifg, d0_done, d0_en, d0_we, d0_stall;
  logic [31:0] d0_ifrd, d0_mrd, d0_maddr, d0_mwd, d0_rdin;
  logic        d1_ifg, d1_done, d1_en, d1_we, d1_stall;
  logic [31:0] d1_ifrd, d1_mrd, d1_maddr, d1_mwd, d1_rdin;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h2011_0013;
  endfunction

  assign d0_rdin = mem_fn(d0_maddr);
  assign d1_rdin = mem_fn(d1_maddr);

  mem_port_arbiter #(.LATENCY(2)) u_dut0 (
    .Clk(Clk), .Reset(Reset),
    .IF_Req(if_req), .IF_Addr(if_addr), .IF_Grant(d0_ifg), .IF_RData(d0_ifrd),
    .MEM_Req(mem_req), .MEM_Wre(mem_wre), .MEM_Addr(mem_addr), .MEM_WData(mem_wdata),
    .MEM_Done(d0_done), .MEM_RData(d0_mrd),
    .Mem_En(d0_en), .Mem_We(d0_we), .Mem_Addr(d0_maddr), .Mem_WData(d0_mwd),
    .Mem_RData(d0_rdin), .PipeStall(d0_stall)
  );

  mem_port_arbiter #(.LATENCY(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .IF_Req(if_req), .IF_Addr(if_addr), .IF_Grant(d1_ifg), .IF_RData(d1_ifrd),
    .MEM_Req(mem_req), .MEM_Wre(mem_wre), .MEM_Addr(mem_addr), .MEM_WData(mem_wdata),
    .MEM_Done(d1_done), .MEM_RData(d1_mrd),
    .Mem_En(d1_en), .Mem_We(d1_we), .Mem_Addr(d1_maddr), .Mem_WData(d1_mwd),
    .Mem_RData(d1_rdin), .PipeStall(d1_stall)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_wre;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        grant;
    logic        done;
    logic [31:0] if_rd;
    logic [31:0] mem_rd;
    logic        stall;
  } vec_t;

  vec_t ta[13];
  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_wre = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
  endtask

  task automatic do_reset();
    drive_idle();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst en", 32'(d0_en), 32'h0);
    chk("rst grant", 32'(d0_ifg), 32'h0);
    chk("rst done", 32'(d0_done), 32'h0);
    chk("rst if_rdata", d0_ifrd, 32'h0);
    chk("rst mem_rdata", d0_mrd, 32'h0);
    chk("rst stall", 32'(d0_stall), 32'h0);
    chk("rst l1 if_rdata", d1_ifrd, 32'h0);
    @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic apply(input vec_t v, input bit sel, input int row);
    string p;
    p = $sformatf("%s row%0d", sel ? "L1" : "L2", row);
    if_req = v.if_req; if_addr = v.if_addr;
    mem_req = v.mem_req; mem_wre = v.mem_wre; mem_addr = v.mem_addr; mem_wdata = v.mem_wdata;
    @(negedge Clk);
    chk({p, " en"},     32'(sel ? d1_en : d0_en),       32'(v.en));
    chk({p, " we"},     32'(sel ? d1_we : d0_we),       32'(v.we));
    chk({p, " addr"},   sel ? d1_maddr : d0_maddr,      v.addr);
    chk({p, " wdata"},  sel ? d1_mwd : d0_mwd,          v.wdata);
    chk({p, " grant"},  32'(sel ? d1_ifg : d0_ifg),     32'(v.grant));
    chk({p, " done"},   32'(sel ? d1_done : d0_done),   32'(v.done));
    chk({p, " if_rd"},  sel ? d1_ifrd : d0_ifrd,        v.if_rd);
    chk({p, " mem_rd"}, sel ? d1_mrd : d0_mrd,          v.mem_rd);
    chk({p, " stall"},  32'(sel ? d1_stall : d0_stall), 32'(v.stall));
    @(posedge Clk);
    #1;
  endtask

  // Reference model: a slot starts at the IDLE cycle that wins arbitration; the access
  // occupies positions 1..L, the response pulse is at L+1, and the port is free afterwards.
  localparam int L = 2;
  int          cyc;
  int          slot_start;
  bit          m_owner, m_last, m_we;
  logic [31:0] m_addr, m_wd, m_ifrd, m_memrd;
  bit          prev_grant, prev_done;

  task automatic model_cycle(input bit drain);
    int pos;
    bit e_acc, e_grant, e_done, idle, win;
    pos     = cyc - slot_start;
    e_acc   = (pos >= 1) && (pos <= L);
    e_grant = (pos == L + 1) && !m_owner;
    e_done  = (pos == L + 1) && m_owner;
    idle    = !((pos >= 1) && (pos <= L + 1));

    if (e_acc && !m_owner) if_req = 1'($urandom % 2);
    else if (!(if_req && !prev_grant)) if_req = drain ? 1'b0 : 1'($urandom % 2);
    if (e_acc && m_owner) mem_req = 1'($urandom % 2);
    else if (!(mem_req && !prev_done)) mem_req = drain ? 1'b0 : 1'($urandom % 2);
    if_addr   = $urandom & 32'hFFFF_FFFC;
    mem_addr  = $urandom & 32'hFFFF_FFFC;
    mem_wdata = $urandom;
    mem_wre   = 1'($urandom % 2);

    @(negedge Clk);
    chk("rnd en", 32'(d0_en), 32'(e_acc));
    chk("rnd we", 32'(d0_we), 32'(e_acc && m_owner && m_we));
    chk("rnd addr", d0_maddr, e_acc ? m_addr : 32'h0);
    chk("rnd wdata", d0_mwd, e_acc ? m_wd : 32'h0);
    chk("rnd grant", 32'(d0_ifg), 32'(e_grant));
    chk("rnd done", 32'(d0_done), 32'(e_done));
    chk("rnd if_rd", d0_ifrd, m_ifrd);
    chk("rnd mem_rd", d0_mrd, m_memrd);
    chk("rnd stall", 32'(d0_stall), 32'((if_req && !e_grant) || (mem_req && !e_done)));

    if (pos == L) begin
      if (!m_owner) m_ifrd = mem_fn(m_addr);
      else if (!m_we) m_memrd = mem_fn(m_addr);
    end
    if (idle && (if_req || mem_req)) begin
      win        = mem_req && (!if_req || !m_last);
      slot_start = cyc;
      m_owner    = win;
      m_last     = win;
      m_addr     = win ? mem_addr : if_addr;
      m_wd       = win ? mem_wdata : 32'h0;
      m_we       = win && mem_wre;
    end
    prev_grant = e_grant;
    prev_done  = e_done;
    @(posedge Clk);
    #1 cyc++;
  endtask

  initial begin
    logic [31:0] f20, f10, f0, f4, f8;
    f20 = mem_fn(32'h20); f10 = mem_fn(32'h10);
    f0  = mem_fn(32'h0);  f4  = mem_fn(32'h4);  f8 = mem_fn(32'h8);

    // LATENCY=2: tie out of reset (MEM first), then IF fetch, then MEM write dropped mid-access.
    ta[0]  = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    ta[1]  = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    ta[2]  = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h44, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    ta[3]  = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 32'h0, f20,   1'b1};
    ta[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0, f20,   1'b1};
    ta[5]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0, f20,   1'b1};
    ta[6]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0, f20,   1'b1};
    ta[7]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, f10,   f20,   1'b0};
    ta[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, f10,   f20,   1'b1};
    ta[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  32'hDEADBEEF, 1'b1, 1'b1, 32'h8,  32'hDEADBEEF, 1'b0, 1'b0, f10,   f20,   1'b1};
    ta[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'hC,  32'h1234,     1'b1, 1'b1, 32'h8,  32'hDEADBEEF, 1'b0, 1'b0, f10,   f20,   1'b0};
    ta[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b1, f10,   f20,   1'b0};
    ta[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, f10,   f20,   1'b0};

    // LATENCY=1: back-to-back IF reads at 0x0, 0x4, 0x8, one grant every three cycles.
    tv[0] = '{1'b1, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    tv[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    tv[2] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f0,    32'h0, 1'b0};
    tv[3] = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, f0,    32'h0, 1'b1};
    tv[4] = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, f0,    32'h0, 1'b1};
    tv[5] = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f4,    32'h0, 1'b0};
    tv[6] = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, f4,    32'h0, 1'b1};
    tv[7] = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, f4,    32'h0, 1'b1};
    tv[8] = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f8,    32'h0, 1'b0};
    tv[9] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, f8,    32'h0, 1'b0};

    do_reset();
    for (int i = 0; i < 13; i++) apply(ta[i], 1'b0, i);
    do_reset();
    for (int i = 0; i < 10; i++) apply(tv[i], 1'b1, i);

    // Random traffic on the LATENCY=2 instance, then drain to IDLE.
    do_reset();
    cyc = 0; slot_start = -100;
    m_owner = 1'b0; m_last = 1'b0; m_we = 1'b0;
    m_addr = 32'h0; m_wd = 32'h0; m_ifrd = 32'h0; m_memrd = 32'h0;
    prev_grant = 1'b0; prev_done = 1'b0;
    for (int i = 0; i < 400; i++) model_cycle(1'b0);
    for (int i = 0; i < 20; i++) model_cycle(1'b1);

    // Reset in the 2nd ACCESS cycle aborts the access without waiting for a clock.
    drive_idle();
    if_req = 1'b1; if_addr = 32'h30;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("abort en before", 32'(d0_en), 32'h1);
    chk("abort addr before", d0_maddr, 32'h30);
    #2 Reset = 1'b1;
    #1;
    chk("abort en async", 32'(d0_en), 32'h0);
    chk("abort we async", 32'(d0_we), 32'h0);
    chk("abort addr async", d0_maddr, 32'h0);
    chk("abort if_rd", d0_ifrd, 32'h0);
    chk("abort mem_rd", d0_mrd, 32'h0);
    if_req = 1'b0;
    @(posedge Clk); #1 Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("abort no grant", 32'(d0_ifg), 32'h0);
      chk("abort no done", 32'(d0_done), 32'h0);
      chk("abort idle en", 32'(d0_en), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one parameter: LATENCY, default 2, meaning the number of memory access cycles (legal range 1..7).
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-003 Clk  in  1  clock; all state changes on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 IF_Req  in  1  fetch request; level signal held until IF_Grant.
REQ-006 IF_Addr  in  32  fetch address.
REQ-007 IF_Grant  out  1  one-cycle pulse; IF_RData valid in this cycle.
REQ-008 IF_RData  out  32  registered fetch data.
REQ-009 MEM_Req  in  1  data-stage request; level signal held until MEM_Done.
REQ-010 MEM_Wre  in  1  1 = write, 0 = read; qualified by MEM_Req.
REQ-011 MEM_Addr  in  32  data address.
REQ-012 MEM_WData  in  32  write data.
REQ-013 MEM_Done  out  1  one-cycle completion pulse.
REQ-014 MEM_RData  out  32  registered read data.
REQ-015 Mem_En  out  1  shared memory enable.
REQ-016 Mem_We  out  1  shared memory write enable.
REQ-017 Mem_Addr  out  32  shared memory address.
REQ-018 Mem_WData  out  32  shared memory write data.
REQ-019 Mem_RData  in  32  shared memory read data; valid in the last ACCESS cycle.
REQ-020 PipeStall  out  1  pipeline freeze request to the hazard logic.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-022 Transitions SHALL be:
- IDLE->ACCESS when either request is high.
- ACCESS->RESP when cnt == LATENCY-1.
- RESP->IDLE always.
REQ-023 In IDLE with both requests high, the winner SHALL be the requester not recorded in the last_served flag (round-robin); with one request high, that requester SHALL win.
REQ-024 On the IDLE->ACCESS edge, the block SHALL latch:
- the owner;
- the address, write data and write flag from the winning requester;
- cnt cleared to 0;
- last_served set to the winner.
REQ-025 During ACCESS, the memory port SHALL be driven as follows:
- Mem_En = 1.
- Mem_Addr and Mem_WData from the latched values.
- Mem_We = 1 only when the owner is MEM and the latched write flag is 1.
- cnt increments by 1 per cycle.
REQ-026 Outside ACCESS, Mem_En, Mem_We, Mem_Addr and Mem_WData SHALL all be 0.
REQ-027 On the ACCESS->RESP edge:
- A read SHALL capture Mem_RData into the owner's RData register.
- A write SHALL leave MEM_RData unchanged.
- The idle requester's RData SHALL be unchanged.
REQ-028 In RESP, exactly one of IF_Grant / MEM_Done (the owner's) SHALL be 1; both SHALL be 0 in every other state.
REQ-029 Requesters SHALL drop or renew their request at the edge ending RESP; a request seen in the following IDLE cycle SHALL be treated as a new access.
REQ-030 Access latency from an IDLE sample to the Grant/Done pulse SHALL be LATENCY+1 cycles; the total slot is LATENCY+2 cycles including IDLE.
REQ-031 PipeStall SHALL be combinational and equal to (IF_Req & ~IF_Grant) | (MEM_Req & ~MEM_Done).
REQ-032 Request inputs SHALL be ignored outside IDLE; input address or data changes during ACCESS SHALL have no effect.
REQ-033 The cnt register SHALL be 3 bits wide; with LATENCY=1, ACCESS SHALL last exactly one cycle.
REQ-034 A request that drops during ACCESS SHALL still complete the access and pulse Grant/Done.

Reset
REQ-035 While Reset=1, the block SHALL set:
- state = IDLE, cnt = 0;
- last_served = IF, so MEM wins the first tie;
- all outputs = 0, including IF_RData, MEM_RData and PipeStall (given its inputs).
REQ-036 Reset asserted mid-ACCESS SHALL abort the access immediately: Mem_En and Mem_We fall asynchronously, and no Grant/Done pulse is issued afterwards.
REQ-037 After Reset deasserts, the first arbitration SHALL occur at the first rising edge that sees IDLE with a request high.

Verification
REQ-038 Single fetch: LATENCY=2, IF_Req=1, IF_Addr=0x00000010, Mem_RData=0x20110003 -> Mem_En high for 2 cycles with Mem_Addr=0x10, IF_Grant pulses 3 cycles after the IDLE sample, IF_RData=0x20110003.
REQ-039 Tie: IF_Req and MEM_Req (read) both raised out of reset -> MEM served first (MEM_Done), then IF (IF_Grant); PipeStall=1 until IF_Grant.
REQ-040 Fairness: MEM_Req held continuously (renewed each RESP) with IF_Req=1 -> grants alternate MEM, IF, MEM, IF; no more than one MEM access between IF grants.
REQ-041 Write: MEM_Req=1, MEM_Wre=1, MEM_Addr=0x8, MEM_WData=0xDEADBEEF -> Mem_We=1 exactly during ACCESS, MEM_Done pulses, MEM_RData retains its prior value.
REQ-042 Reset mid-access: Reset asserted in the 2nd ACCESS cycle -> Mem_En drops without waiting for a clock, no Grant or Done pulse occurs, state is IDLE and the RData registers are 0.
REQ-043 LATENCY=1 sweep: back-to-back IF reads at 0x0, 0x4, 0x8 -> one grant every 3 cycles with correct data ordering.
